// File: rtl/ahb_uart_tx_fifo_pkg.sv
// Shared definitions for the buffered AHB-Lite UART transmitter: register
// offsets, STATUS bit positions, FSM encoding and the divider helper.
package ahb_uart_tx_fifo_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_BAUDDIV = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVF   = 3;
  localparam int unsigned STAT_COUNT = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // A programmed divider of zero runs at one HCLK per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/ahb_uart_tx_fifo_if.sv
// AHB-Lite slave-side bus bundle for the UART transmitter.
interface ahb_uart_tx_fifo_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO of depth 2**AW; reset clears pointers and count only.
module uart_tx_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally; count stays put on simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = count_r[AW];
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;

endmodule

// File: rtl/ahb_uart_tx_fifo.sv
// AHB-Lite UART transmitter, 8N1 LSB first, with a byte FIFO and a
// programmable HCLK-per-bit divider.
module ahb_uart_tx_fifo
  import ahb_uart_tx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4,
  parameter logic [15:0] DIV_RST = 16'd26
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_uart_tx_fifo_if.slave ahb,
  output logic              UART_TX,
  output logic              TXIRQ
);

  logic             accept_s, wr_dp_s, push_req_s, push_s, pop_s;
  logic             full_s, empty_s, bit_end_s, busy_s, unused_s;
  logic [7:0]       fifo_rdata_s;
  logic [FIFO_AW:0] count_s;
  logic [15:0]      div_load_s;
  logic [31:0]      rdata_s;

  logic             dp_wr_r, dp_rd_r;
  logic [1:0]       dp_addr_r;
  logic [15:0]      baud_div_r, timer_r;
  logic             txen_r, irqen_r, ovf_r, tx_r;
  logic [1:0]       state_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;

  assign accept_s   = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign wr_dp_s    = dp_wr_r & ahb.HREADY;
  assign push_req_s = wr_dp_s & (dp_addr_r == ADDR_DATA);
  // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push_s     = push_req_s & ~full_s;
  assign bit_end_s  = (timer_r == 16'd0);
  assign div_load_s = eff_div(baud_div_r) - 16'd1;
  assign busy_s     = (state_r != S_IDLE);
  assign unused_s   = ^{ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0],
                        ahb.HTRANS[0], ahb.HWDATA[31:16]};

  uart_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (ahb.HWDATA[7:0]),
    .rdata (fifo_rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Address-phase capture for the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_wr_r   <= 1'b0;
      dp_rd_r   <= 1'b0;
      dp_addr_r <= 2'd0;
    end else if (ahb.HREADY) begin
      dp_wr_r   <= accept_s & ahb.HWRITE;
      dp_rd_r   <= accept_s & ~ahb.HWRITE;
      dp_addr_r <= ahb.HADDR[3:2];
    end
  end

  // Control registers and the sticky overflow flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      baud_div_r <= DIV_RST;
      txen_r     <= 1'b1;
      irqen_r    <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      if (wr_dp_s && (dp_addr_r == ADDR_BAUDDIV)) begin
        baud_div_r <= ahb.HWDATA[15:0];
      end
      if (wr_dp_s && (dp_addr_r == ADDR_CTRL)) begin
        txen_r  <= ahb.HWDATA[0];
        irqen_r <= ahb.HWDATA[1];
      end
      if (push_req_s && full_s) begin
        ovf_r <= 1'b1;
      end else if (wr_dp_s && (dp_addr_r == ADDR_STATUS) && ahb.HWDATA[STAT_OVF]) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Pop when idle, or back-to-back at the end of a stop bit.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      S_IDLE:  pop_s = txen_r & ~empty_s;
      S_STOP:  pop_s = txen_r & ~empty_s & bit_end_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Frame shifter; the divider is sampled only when a bit starts.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r   <= S_IDLE;
      timer_r   <= 16'd0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            state_r <= S_START;
            tx_r    <= 1'b0;
            timer_r <= div_load_s;
            shift_r <= fifo_rdata_s;
          end
        end
        S_START: begin
          if (bit_end_s) begin
            state_r   <= S_DATA;
            tx_r      <= shift_r[0];
            timer_r   <= div_load_s;
            bit_cnt_r <= 3'd0;
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            timer_r <= div_load_s;
            if (bit_cnt_r == 3'd7) begin
              state_r <= S_STOP;
              tx_r    <= 1'b1;
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end_s) begin
            if (pop_s) begin
              state_r <= S_START;
              tx_r    <= 1'b0;
              timer_r <= div_load_s;
              shift_r <= fifo_rdata_s;
            end else begin
              state_r <= S_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  // Read mux driven from the registered data-phase address.
  always_comb begin
    rdata_s = 32'd0;
    if (dp_rd_r) begin
      case (dp_addr_r)
        ADDR_STATUS: begin
          rdata_s[STAT_FULL]                  = full_s;
          rdata_s[STAT_EMPTY]                 = empty_s;
          rdata_s[STAT_BUSY]                  = busy_s;
          rdata_s[STAT_OVF]                   = ovf_r;
          rdata_s[STAT_COUNT +: (FIFO_AW+1)]  = count_s;
        end
        ADDR_BAUDDIV: rdata_s[15:0] = baud_div_r;
        ADDR_CTRL:    rdata_s[1:0]  = {irqen_r, txen_r};
        default:      rdata_s       = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign ahb.HRDATA    = rdata_s;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign UART_TX       = tx_r;
  assign TXIRQ         = irqen_r & empty_s & ~busy_s;

endmodule

// File: tb/tb_ahb_uart_tx_fifo.sv
// Directed bench for ahb_uart_tx_fifo: register access, frame timing,
// FIFO overflow, interrupt, divider change and mid-frame reset.
module tb_ahb_uart_tx_fifo;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic UART_TX;
  logic TXIRQ;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  ahb_uart_tx_fifo_if bus();

  ahb_uart_tx_fifo #(.FIFO_AW(4), .DIV_RST(16'd26)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus),
    .UART_TX (UART_TX),
    .TXIRQ   (TXIRQ)
  );

  always #5 HCLK = ~HCLK;

  // Expected line level for bit slot idx of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  // Returns one ns after the edge that ends the data phase.
  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = {28'd0, a};
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {28'd0, a};
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    d = bus.HRDATA;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    cmp_cnt++; if (UART_TX !== 1'b1) begin err_cnt++; $display("FAIL reset_tx: got %b expected 1", UART_TX); end
    cmp_cnt++; if (TXIRQ !== 1'b0) begin err_cnt++; $display("FAIL reset_irq: got %b expected 0", TXIRQ); end
    cmp_cnt++; if (bus.HRDATA !== 32'd0) begin err_cnt++; $display("FAIL reset_hrdata: got %h expected 0", bus.HRDATA); end
    ahb_read(4'h4, rd);
    cmp_cnt++; if (rd !== 32'h002) begin err_cnt++; $display("FAIL reset_status: got %h expected 002", rd); end
    ahb_read(4'h8, rd);
    cmp_cnt++; if (rd !== 32'd26) begin err_cnt++; $display("FAIL reset_bauddiv: got %0d expected 26", rd); end
    ahb_read(4'hC, rd);
    cmp_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL reset_ctrl: got %h expected 1", rd); end
  endtask

  task automatic test_frame;
    logic [31:0] rd;
    logic [7:0]  b;
    logic        exp;
    b = 8'h55;
    ahb_write(4'h8, 32'd4);
    ahb_write(4'h0, {24'd0, b});
    cmp_cnt++; if (UART_TX !== 1'b1) begin err_cnt++; $display("FAIL frame_at_push: got %b expected 1", UART_TX); end
    for (int c = 0; c < 40; c++) begin
      @(posedge HCLK); #1;
      exp = frame_bit(b, c / 4);
      cmp_cnt++; if (UART_TX !== exp) begin err_cnt++; $display("FAIL frame_bit c=%0d: got %b expected %b", c, UART_TX, exp); end
    end
    @(posedge HCLK); #1;
    cmp_cnt++; if (UART_TX !== 1'b1) begin err_cnt++; $display("FAIL frame_end_tx: got %b expected 1", UART_TX); end
    ahb_read(4'h4, rd);
    cmp_cnt++; if (rd !== 32'h002) begin err_cnt++; $display("FAIL frame_end_status: got %h expected 002", rd); end
  endtask

  task automatic test_overflow;
    logic [31:0] rd;
    logic [7:0]  b;
    logic        exp;
    ahb_write(4'hC, 32'd0);
    for (int i = 0; i < 17; i++) begin
      b = 8'h10 + 8'(i);
      ahb_write(4'h0, {24'd0, b});
    end
    ahb_read(4'h4, rd);
    cmp_cnt++; if (rd !== 32'h1009) begin err_cnt++; $display("FAIL ovf_status_full: got %h expected 1009", rd); end
    ahb_write(4'hC, 32'd1);
    for (int f = 0; f < 16; f++) begin
      b = 8'h10 + 8'(f);
      for (int c = 0; c < 40; c++) begin
        @(posedge HCLK); #1;
        exp = frame_bit(b, c / 4);
        cmp_cnt++; if (UART_TX !== exp) begin err_cnt++; $display("FAIL b2b_frame%0d c=%0d: got %b expected %b", f, c, UART_TX, exp); end
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge HCLK); #1;
      cmp_cnt++; if (UART_TX !== 1'b1) begin err_cnt++; $display("FAIL no_byte17 c=%0d: got %b expected 1", c, UART_TX); end
    end
    ahb_read(4'h4, rd);
    cmp_cnt++; if (rd !== 32'h00A) begin err_cnt++; $display("FAIL ovf_status_drained: got %h expected 00a", rd); end
    ahb_write(4'h4, 32'h8);
    ahb_read(4'h4, rd);
    cmp_cnt++; if (rd !== 32'h002) begin err_cnt++; $display("FAIL ovf_clear: got %h expected 002", rd); end
  endtask

  task automatic test_irq;
    ahb_write(4'hC, 32'd3);
    cmp_cnt++; if (TXIRQ !== 1'b1) begin err_cnt++; $display("FAIL irq_idle: got %b expected 1", TXIRQ); end
    ahb_write(4'h0, 32'hA3);
    cmp_cnt++; if (TXIRQ !== 1'b0) begin err_cnt++; $display("FAIL irq_after_push: got %b expected 0", TXIRQ); end
    for (int c = 0; c < 40; c++) begin
      @(posedge HCLK); #1;
      cmp_cnt++; if (TXIRQ !== 1'b0) begin err_cnt++; $display("FAIL irq_in_frame c=%0d: got %b expected 0", c, TXIRQ); end
    end
    @(posedge HCLK); #1;
    cmp_cnt++; if (TXIRQ !== 1'b1) begin err_cnt++; $display("FAIL irq_after_stop: got %b expected 1", TXIRQ); end
    ahb_write(4'hC, 32'd1);
    cmp_cnt++; if (TXIRQ !== 1'b0) begin err_cnt++; $display("FAIL irq_disabled: got %b expected 0", TXIRQ); end
  endtask

  // Divider moves 4 -> 8 while data bit 3 (cycles 16..19) is on the line.
  task automatic test_baud_change;
    logic [31:0] rd;
    logic [7:0]  b;
    logic        exp;
    b = 8'hAA;
    ahb_write(4'h0, {24'd0, b});
    for (int c = 0; c <= 16; c++) begin
      @(posedge HCLK); #1;
      exp = (c < 4) ? 1'b0 : b[(c-4)/4];
      cmp_cnt++; if (UART_TX !== exp) begin err_cnt++; $display("FAIL baud_old c=%0d: got %b expected %b", c, UART_TX, exp); end
    end
    ahb_write(4'h8, 32'd8);
    cmp_cnt++; if (UART_TX !== b[3]) begin err_cnt++; $display("FAIL baud_bit3_tail: got %b expected %b", UART_TX, b[3]); end
    for (int c = 20; c < 60; c++) begin
      @(posedge HCLK); #1;
      exp = (c < 52) ? b[4 + (c-20)/8] : 1'b1;
      cmp_cnt++; if (UART_TX !== exp) begin err_cnt++; $display("FAIL baud_new c=%0d: got %b expected %b", c, UART_TX, exp); end
    end
    ahb_read(4'h4, rd);
    cmp_cnt++; if (rd !== 32'h002) begin err_cnt++; $display("FAIL baud_end_status: got %h expected 002", rd); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] rd;
    ahb_write(4'h8, 32'd4);
    ahb_write(4'h0, 32'h00);
    ahb_write(4'h0, 32'h11);
    ahb_write(4'h0, 32'h22);
    cmp_cnt++; if (UART_TX !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_bit0: got %b expected 0", UART_TX); end
    #2; HRESETn = 1'b0; #1;
    cmp_cnt++; if (UART_TX !== 1'b1) begin err_cnt++; $display("FAIL rst_async_tx: got %b expected 1", UART_TX); end
    repeat (2) @(posedge HCLK);
    #3; HRESETn = 1'b1;
    ahb_read(4'h4, rd);
    cmp_cnt++; if (rd !== 32'h002) begin err_cnt++; $display("FAIL rst_status: got %h expected 002", rd); end
    ahb_read(4'h8, rd);
    cmp_cnt++; if (rd !== 32'd26) begin err_cnt++; $display("FAIL rst_bauddiv: got %0d expected 26", rd); end
    repeat (5) @(posedge HCLK);
    #1;
    cmp_cnt++; if (UART_TX !== 1'b1) begin err_cnt++; $display("FAIL rst_tx_idle: got %b expected 1", UART_TX); end
  endtask

  initial begin
    HRESETn    = 1'b0;
    bus.HSEL   = 1'b0;
    bus.HREADY = 1'b1;
    bus.HADDR  = 32'd0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = 32'd0;
    #22 HRESETn = 1'b1;
    test_reset;
    test_frame;
    test_overflow;
    test_irq;
    test_baud_change;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
